// File: rtl/ex1_seq_decoder.sv
// ex1_seq_decoder: recovers Y from the ex1 T-flip-flop generator state,
// tracks lock, deframes words. Optional parity: EX1_SEQ_DEC_PARITY_EN.
module ex1_seq_decoder #(
    parameter int WORD_W      = 8,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 A,
    input  logic                 B,
    input  logic                 C,
    input  logic                 D,
    output logic                 y_bit,
    output logic                 y_bit_valid,
    output logic                 illegal,
    output logic                 locked,
    output logic [WORD_W-1:0]    word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overrun,
`ifdef EX1_SEQ_DEC_PARITY_EN
    output logic                 parity_err,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef EX1_SEQ_DEC_PARITY_EN
    localparam int FRAME = WORD_W + 1;
    localparam int SR_W  = WORD_W;
`else
    localparam int FRAME = WORD_W;
    localparam int SR_W  = WORD_W - 1;
`endif
    localparam int BC_W = $clog2(FRAME + 1);
    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int BD_W = $clog2(UNLOCK_ERRS + 1);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_CNT - 1);
    localparam logic [BD_W-1:0] BD_LAST = BD_W'(UNLOCK_ERRS - 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state;
    logic [3:0]        prev;
    logic              prev_valid;
    logic [GC_W-1:0]   good_cnt;
    logic [BD_W-1:0]   bad_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [SR_W-1:0]   shreg;

    logic              t_a;
    logic              t_b;
    logic              t_c;
    logic              t_d;
    logic              dec_y;
    logic              dec_legal;
    logic              dec_illegal;
    logic              frame_last;
    logic              frame_done;
    logic              par_ok;
    logic              can_load;
    logic [WORD_W-1:0] new_word;

    // Invert the generator: toggles reveal Y, then verify the equations
    always_comb begin
        t_a         = A ^ prev[3];
        t_b         = B ^ prev[2];
        t_c         = C ^ prev[1];
        t_d         = D ^ prev[0];
        dec_y       = t_b ? prev[1] : ~prev[1];
        dec_legal   = prev_valid & t_c & ~t_d
                    & (t_a == (dec_y & (prev[2] == prev[1])));
        dec_illegal = prev_valid & ~dec_legal;
    end

    // Frame completion, candidate word and parity check
    always_comb begin
        frame_last = (bit_cnt == BC_LAST);
        frame_done = (state == LOCK) & dec_legal & frame_last;
        can_load   = ~word_valid | word_ready;
`ifdef EX1_SEQ_DEC_PARITY_EN
        new_word   = shreg;
        par_ok     = ((^shreg) == dec_y);
`else
        new_word   = {shreg, dec_y};
        par_ok     = 1'b1;
`endif
    end

    // Sample generator state and register the per-transition decode
    always_ff @(posedge clock) begin
        if (reset) begin
            prev        <= '0;
            prev_valid  <= 1'b0;
            y_bit       <= 1'b0;
            y_bit_valid <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            prev        <= {A, B, C, D};
            prev_valid  <= 1'b1;
            y_bit_valid <= dec_legal;
            illegal     <= dec_illegal;
            if (dec_legal) begin
                y_bit <= dec_y;
            end
        end
    end

    // HUNT/LOCK tracking, bit shifting and error accounting
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= HUNT;
            locked   <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            err_cnt  <= '0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (dec_legal) begin
                        if (good_cnt == GC_LAST) begin
                            state    <= LOCK;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                            bit_cnt  <= '0;
                            shreg    <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end else if (dec_illegal) begin
                        good_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (dec_legal) begin
                        bad_cnt <= '0;
                        bit_cnt <= frame_last ? '0 : bit_cnt + 1'b1;
`ifdef EX1_SEQ_DEC_PARITY_EN
                        if (!frame_last) begin
                            shreg <= {shreg[SR_W-2:0], dec_y};
                        end
`else
                        shreg <= new_word[WORD_W-2:0];
`endif
                    end else if (dec_illegal) begin
                        bit_cnt <= '0;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        if (bad_cnt == BD_LAST) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Holding register with valid/ready; a busy register drops new words
    always_ff @(posedge clock) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef EX1_SEQ_DEC_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef EX1_SEQ_DEC_PARITY_EN
            parity_err <= frame_done & ~par_ok;
`endif
            if (frame_done && par_ok && can_load) begin
                word_out   <= new_word;
                word_valid <= 1'b1;
            end else begin
                if (frame_done && par_ok) begin
                    overrun <= 1'b1;
                end
                if (word_valid && word_ready) begin
                    word_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex1_seq_decoder.sv
// tb_ex1_seq_decoder: table-driven decode/lock vectors plus
// hand sequences for framing, handshake, overrun and reset.
module tb_ex1_seq_decoder;

    localparam int WORD_W = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              A;
    logic              B;
    logic              C;
    logic              D;
    logic              y_bit;
    logic              y_bit_valid;
    logic              illegal;
    logic              locked;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              overrun;
    logic [7:0]        err_cnt;
`ifdef EX1_SEQ_DEC_PARITY_EN
    logic              parity_err;
`endif

    ex1_seq_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .A           (A),
        .B           (B),
        .C           (C),
        .D           (D),
        .y_bit       (y_bit),
        .y_bit_valid (y_bit_valid),
        .illegal     (illegal),
        .locked      (locked),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
`ifdef EX1_SEQ_DEC_PARITY_EN
        .parity_err  (parity_err),
`endif
        .err_cnt     (err_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] st;
        logic       y;
        logic       yv;
        logic       ill;
        logic       lk;
        logic [7:0] err;
    } vec_t;

    vec_t       tbl[14];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] cur;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] s,
                        input logic rdy);
        reset      = rst;
        {A, B, C, D} = s;
        word_ready = rdy;
        cur        = s;
        @(posedge clock);
        #1;
    endtask

    // Reference generator: T-flip-flop next state for input y
    function automatic logic [3:0] gen(input logic [3:0] s, input logic y);
        logic tgb;
        logic tga;
        tgb = ~(s[1] ^ y);
        tga = y & (s[2] == s[1]);
        return {s[3] ^ tga, s[2] ^ tgb, ~s[1], s[0]};
    endfunction

    task automatic send_bit(input logic y, input logic rdy);
        step(1'b0, gen(cur, y), rdy);
        chk("y_bit_valid", {31'd0, y_bit_valid}, 32'd1);
        chk("y_bit", {31'd0, y_bit}, {31'd0, y});
    endtask

    task automatic do_lock();
        step(1'b1, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        repeat (4) send_bit(1'b0, 1'b0);
        chk("locked after 4", {31'd0, locked}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic rdy_last,
                             input logic exp_load, input logic exp_ovr);
        logic [7:0] w;
        if (exp_load) exp_q.push_back(data);
`ifdef EX1_SEQ_DEC_PARITY_EN
        for (int i = WORD_W - 1; i >= 0; i--) send_bit(data[i], 1'b0);
        send_bit(^data, rdy_last);
        chk("parity_err", {31'd0, parity_err}, 32'd0);
`else
        for (int i = WORD_W - 1; i >= 0; i--)
            send_bit(data[i], (i == 0) ? rdy_last : 1'b0);
`endif
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        if (exp_load) begin
            w = exp_q.pop_front();
            chk("word_out", {24'd0, word_out}, {24'd0, w});
            chk("word_valid", {31'd0, word_valid}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[9]  = '{1'b0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
        tbl[10] = '{1'b0, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[11] = '{1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
        tbl[12] = '{1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};
        tbl[13] = '{1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].st, 1'b0);
            chk($sformatf("v%0d y_bit", i), {31'd0, y_bit}, {31'd0, tbl[i].y});
            chk($sformatf("v%0d y_valid", i), {31'd0, y_bit_valid},
                {31'd0, tbl[i].yv});
            chk($sformatf("v%0d illegal", i), {31'd0, illegal},
                {31'd0, tbl[i].ill});
            chk($sformatf("v%0d locked", i), {31'd0, locked},
                {31'd0, tbl[i].lk});
            chk($sformatf("v%0d err_cnt", i), {24'd0, err_cnt},
                {24'd0, tbl[i].err});
            chk($sformatf("v%0d word_valid", i), {31'd0, word_valid}, 32'd0);
        end

        // Word then one-cycle accept
        do_lock();
        send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("valid after accept", {31'd0, word_valid}, 32'd0);

        // Overrun drops second word
        do_lock();
        send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("word kept on overrun", {24'd0, word_out}, 32'hA5);
        send_bit(1'b0, 1'b0);
        chk("overrun single pulse", {31'd0, overrun}, 32'd0);

        // Accept on completing cycle loads the new word
        do_lock();
        send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b0);

        // Illegal in LOCK discards partial word; unlock; holding survives
        do_lock();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        step(1'b0, cur, 1'b0);
        chk("lock illegal", {31'd0, illegal}, 32'd1);
        chk("lock err 1", {24'd0, err_cnt}, 32'd1);
        chk("still locked", {31'd0, locked}, 32'd1);
        send_byte(8'h3C, 1'b0, 1'b1, 1'b0);
        step(1'b0, cur, 1'b0);
        chk("err 2", {24'd0, err_cnt}, 32'd2);
        step(1'b0, cur, 1'b0);
        chk("err 3", {24'd0, err_cnt}, 32'd3);
        chk("unlocked", {31'd0, locked}, 32'd0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        chk("hold across hunt", {24'd0, word_out}, 32'h3C);
        chk("valid across hunt", {31'd0, word_valid}, 32'd1);
        chk("no overrun in hunt", {31'd0, overrun}, 32'd0);
        chk("relocked", {31'd0, locked}, 32'd1);

        // Reset mid-word with a pending word and errors
        do_lock();
        send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        step(1'b0, cur, 1'b0);
        chk("pre-reset err", {24'd0, err_cnt}, 32'd1);
        step(1'b1, gen(cur, 1'b1), 1'b0);
        chk("rst y_bit", {31'd0, y_bit}, 32'd0);
        chk("rst y_valid", {31'd0, y_bit_valid}, 32'd0);
        chk("rst illegal", {31'd0, illegal}, 32'd0);
        chk("rst locked", {31'd0, locked}, 32'd0);
        chk("rst word_out", {24'd0, word_out}, 32'd0);
        chk("rst word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst overrun", {31'd0, overrun}, 32'd0);
        chk("rst err_cnt", {24'd0, err_cnt}, 32'd0);

`ifdef EX1_SEQ_DEC_PARITY_EN
        // Bad parity on 0xA5 is flagged and not loaded
        do_lock();
        for (int i = WORD_W - 1; i >= 0; i--) send_bit(((8'hA5 >> i) & 8'h1) != 0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("parity_err pulse", {31'd0, parity_err}, 32'd1);
        chk("no load on bad parity", {31'd0, word_valid}, 32'd0);
        send_bit(1'b0, 1'b0);
        chk("parity_err clears", {31'd0, parity_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex1_seq_decoder.md
Name: ex1_seq_decoder

Overview:
- Receive-side companion to the ex1 T-flip-flop sequence generator. Samples the generator's state bits A, B, C, D every clock.
- Recovers the serial input Y that drove each state transition and checks every transition against the generator's next-state equations.
- Tracks link lock with a HUNT/LOCK state machine and deframes recovered bits into WORD_W-bit words with a valid/ready handshake toward downstream logic.

Parameters:
- WORD_W, 8, bits per deframed word, MSB first
- LOCK_CNT, 4, consecutive legal transitions required to enter LOCK
- UNLOCK_ERRS, 2, consecutive illegal transitions in LOCK that force HUNT
- ERR_CNT_W, 8, width of saturating error counter

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- A  input  1  generator state bit A
- B  input  1  generator state bit B
- C  input  1  generator state bit C
- D  input  1  generator state bit D
- y_bit  output  1  recovered Y for the last transition
- y_bit_valid  output  1  one-cycle pulse per legal transition
- illegal  output  1  one-cycle pulse per illegal transition
- locked  output  1  high while FSM is in LOCK
- word_out  output  WORD_W  holding register
- word_valid  output  1  holding register full
- word_ready  input  1  downstream accepts word when word_valid & word_ready
- overrun  output  1  one-cycle pulse when a completed word is dropped
- err_cnt  output  ERR_CNT_W  saturating count of illegal transitions seen in LOCK

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM=HUNT, prev_valid=0, all counters and shift register 0.
- Each cycle: register prev={A,B,C,D}; set prev_valid=1. The first sample after reset is not decoded.
- Decode when prev_valid=1: tA=A^pA, tB=B^pB, tC=C^pC, tD=D^pD.
  - y = tB ? pC : ~pC (generator toggles B iff C==Y).
  - Legal iff tC==1 and tD==0 and tA==(y & (pB==pC)).
- Latency: the decoded transition is registered; y_bit, y_bit_valid and illegal assert on the edge after the new state is presented. y_bit holds its last value between pulses.
- HUNT state:
  - Legal transition: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCK; clear shift register and bit counter.
  - Illegal transition: good_cnt=0.
  - No bits are shifted and err_cnt does not change in HUNT.
- LOCK state, legal transition:
  - Shift y into shift register MSB first; bit_cnt++; clear bad_cnt.
  - On bit WORD_W: if holding register is empty, or word_ready is accepted this same cycle, load word_out and set word_valid=1. Otherwise pulse overrun and drop the new word; word_out stays unchanged.
  - bit_cnt wraps to 0 after WORD_W.
- LOCK state, illegal transition:
  - err_cnt++ (saturates at all ones); partial word discarded (bit_cnt=0); bad_cnt++.
  - When bad_cnt reaches UNLOCK_ERRS, go to HUNT with good_cnt=0.
- Handshake: word_valid clears on the cycle after word_valid & word_ready. word_out stays stable while word_valid=1.
- Holding register and word_valid survive a LOCK→HUNT transition. Only reset clears them.
- illegal pulses in both states. locked equals (FSM==LOCK), registered.
- Reset asserted mid-word or mid-handshake: everything clears next edge; a pending word is lost.

Optional Feature:
- Macro EX1_SEQ_DEC_PARITY_EN.
- Defined:
  - Frame is WORD_W+1 bits; the final bit is an even-parity bit over the data bits.
  - On frame completion with parity mismatch: no load, one-cycle pulse on extra output port parity_err.
  - On parity match: normal load and overrun rules apply.
- Undefined: frame is WORD_W bits, no parity_err port, no parity logic.

Test Plan:
- Reset, then present 0000 followed by 1010 (generator with Y=1) -> next edge y_bit=1, y_bit_valid=1, illegal=0.
- Present 0000 followed by 0110 (Y=0) -> y_bit=0, y_bit_valid=1. After 4 such legal transitions -> locked=1 one cycle after the 4th.
- After lock, drive a legal sequence encoding Y=1,0,1,0,0,1,0,1 with word_ready=0 -> word_out=0xA5, word_valid=1 held. Assert word_ready one cycle -> word_valid=0 the next cycle.
- Two full words 0xA5 then 0x3C with word_ready=0 -> overrun pulses once, word_out stays 0xA5. Repeat with word_ready=1 on the completing cycle -> word_out=0x3C, no overrun.
- In LOCK, present C unchanged (0000 then 0000) -> illegal=1, err_cnt=1, partial word discarded. A second consecutive illegal -> err_cnt=2, locked=0.
- Inject D=1 on an otherwise legal transition -> illegal=1. Assert reset mid-word -> all outputs 0 next edge. With EX1_SEQ_DEC_PARITY_EN defined, frame 0xA5 with parity bit 1 -> parity_err pulse, word_valid stays 0.
